pixel_pattern_gen: RTL and testbench
====================================

PIXEL_PATTERN_GEN -- requirements
Module: pixel_pattern_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 Parameter BAR_WIDTH, default 80, colour-bar width in pixels.
REQ-004 CLK  input  1  single clock for the whole block; all logic on rising edge.
REQ-005 RESET  input  1  reset, synchronous and active-high.
REQ-006 H_SYNC_IN  input  1  horizontal sync from the timing controller, active-low.
REQ-007 V_SYNC_IN  input  1  vertical sync from the timing controller, active-low.
REQ-008 RGB_EN  input  1  high during visible pixel cycles.
REQ-009 MODE_NEXT  input  1  single-cycle pulse requesting the next test pattern.
REQ-010 H_SYNC  output  1  H_SYNC_IN delayed 1 cycle.
REQ-011 V_SYNC  output  1  V_SYNC_IN delayed 1 cycle.
REQ-012 RED, GREEN, BLUE  output  1 each  pixel colour, registered.
REQ-013 X  output  10  column of the pixel currently on RED/GREEN/BLUE.
REQ-014 Y  output  9  row of the pixel currently on RED/GREEN/BLUE.
REQ-015 MODE  output  2  active pattern: 0 SOLID_RED, 1 COLOR_BARS, 2 GRID, 3 CHECKER.

Function
REQ-016 Internal column counter xc: +1 each cycle RGB_EN=1; cleared to 0 when RGB_EN=0; wraps to 0 after H_ACTIVE-1 if RGB_EN remains high.
REQ-017 Internal row counter yc: +1 on each RGB_EN 1->0 transition (end of visible line); saturates at V_ACTIVE-1.
REQ-018 yc cleared to 0 on V_SYNC_IN 1->0 transition (frame boundary); clear has priority over increment in the same cycle.
REQ-019 Edge detection uses RGB_EN and V_SYNC_IN registered one cycle; no combinational edge paths.
REQ-020 Pattern FSM cycles SOLID_RED -> COLOR_BARS -> GRID -> CHECKER -> SOLID_RED.
REQ-021 MODE_NEXT sets a pending flag; the FSM advances exactly one state at the next frame boundary and clears the pending flag.
REQ-022 Multiple MODE_NEXT pulses within one frame produce a single advance.
REQ-023 MODE_NEXT on the frame-boundary cycle itself causes the advance at that boundary; pending is not left set.
REQ-024 SOLID_RED: R=1, G=0, B=0.
REQ-025 COLOR_BARS: idx = xc / BAR_WIDTH, clamped to 7; {R,G,B} = bitwise NOT of idx[2:0] (white first, black last).
REQ-026 GRID: {R,G,B}=111 when xc[3:0]==0, yc[3:0]==0, xc==H_ACTIVE-1 or yc==V_ACTIVE-1; else 000.
REQ-027 CHECKER: R=G=B = xc[5] XOR yc[5].
REQ-028 Latency: colour, X and Y appear 1 cycle after the RGB_EN cycle that produced them, aligned with H_SYNC/V_SYNC.
REQ-029 When delayed RGB_EN is 0, RED=GREEN=BLUE=0 (driven low, never high-impedance); X and Y hold their last values.
REQ-030 Division by BAR_WIDTH implemented by compare chain or counter; no generic divider.

Reset
REQ-031 RESET=1 at a rising edge: xc=0, yc=0, X=0, Y=0, RED=GREEN=BLUE=0, H_SYNC=1, V_SYNC=1, MODE=0, pending=0, edge registers=idle (RGB_EN reg 0, V_SYNC_IN reg 1).
REQ-032 RESET overrides every other input in the same cycle, including MODE_NEXT and frame boundary.
REQ-033 Reset mid-line or mid-frame: counters restart from 0; first valid pixel after release is the next RGB_EN=1 cycle, reported as X=0, Y=0.

Verification
REQ-034 Reset, then one 640-pixel line in SOLID_RED -> 640 cycles of R=1,G=0,B=0 with X 0..639, one cycle after RGB_EN; outputs 0 during blanking.
REQ-035 MODE_NEXT pulsed three times mid-frame -> MODE stays 0 until V_SYNC_IN falls, then MODE=1 exactly; no further change next frame.
REQ-036 COLOR_BARS line -> X=0..79 RGB=111, X=80..159 RGB=110, ..., X=560..639 RGB=000.
REQ-037 GRID frame -> white at X=0,16,...,624,639 on every line; full white lines at Y=0,16,...,464,479.
REQ-038 MODE_NEXT on the V_SYNC_IN falling-edge cycle from MODE=3 -> MODE=0 at that boundary, pending clear.
REQ-039 RESET asserted at X=300, Y=200 -> all outputs at reset values next cycle; after release next line reports X=0, Y=0, MODE=0.

Source files
------------

// File: rtl/pixel_pattern_gen.sv
// Test-pattern generator: overlays one of four patterns on incoming video
// timing, with registered colour, pixel coordinates and delayed syncs.
module pixel_pattern_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int BAR_WIDTH = 80
) (
    input  logic       osc_clk,
    input  logic       reset,
    input  logic       h_sync_in,
    input  logic       v_sync_in,
    input  logic       rgb_en,
    input  logic       mode_next,
    output logic       h_sync,
    output logic       v_sync,
    output logic       red,
    output logic       green,
    output logic       blue,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        SOLID_RED  = 2'd0,
        COLOR_BARS = 2'd1,
        GRID       = 2'd2,
        CHECKER    = 2'd3
    } pat_t;

    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [8:0] Y_LAST = 9'(V_ACTIVE - 1);

    pat_t       state;
    pat_t       state_nxt;
    logic [9:0] xc;
    logic [8:0] yc;
    logic       en_q;
    logic       vs_q;
    logic       pending;
    logic       frame_start;
    logic       line_end;
    logic [2:0] bar_idx;
    logic [2:0] rgb_nxt;

    assign frame_start = vs_q & ~v_sync_in;
    assign line_end    = en_q & ~rgb_en;
    assign mode        = state;

    always_ff @(posedge osc_clk) begin
        if (reset) begin
            en_q    <= 1'b0;
            vs_q    <= 1'b1;
            h_sync  <= 1'b1;
            v_sync  <= 1'b1;
            xc      <= '0;
            yc      <= '0;
            pending <= 1'b0;
        end else begin
            en_q   <= rgb_en;
            vs_q   <= v_sync_in;
            h_sync <= h_sync_in;
            v_sync <= v_sync_in;

            if (!rgb_en || xc == X_LAST)
                xc <= '0;
            else
                xc <= xc + 10'd1;

            // Frame clear wins over the end-of-line increment
            if (frame_start)
                yc <= '0;
            else if (line_end && yc != Y_LAST)
                yc <= yc + 9'd1;

            if (frame_start)
                pending <= 1'b0;
            else if (mode_next)
                pending <= 1'b1;
        end
    end

    always_ff @(posedge osc_clk) begin
        if (reset)
            state <= SOLID_RED;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (frame_start && (pending || mode_next)) begin
            case (state)
                SOLID_RED:  state_nxt = COLOR_BARS;
                COLOR_BARS: state_nxt = GRID;
                GRID:       state_nxt = CHECKER;
                default:    state_nxt = SOLID_RED;
            endcase
        end
    end

    // Bar index by threshold compare chain, saturating at the last bar
    always_comb begin
        bar_idx = '0;
        for (int k = 1; k < 8; k++) begin
            if (int'(xc) >= k * BAR_WIDTH)
                bar_idx = 3'(k);
        end
    end

    always_comb begin
        rgb_nxt = 3'b000;
        case (state)
            SOLID_RED:  rgb_nxt = 3'b100;
            COLOR_BARS: rgb_nxt = ~bar_idx;
            GRID: begin
                if (xc[3:0] == 4'd0 || yc[3:0] == 4'd0 ||
                    xc == X_LAST || yc == Y_LAST)
                    rgb_nxt = 3'b111;
            end
            default:    rgb_nxt = {3{xc[5] ^ yc[5]}};
        endcase
    end

    always_ff @(posedge osc_clk) begin
        if (reset) begin
            red   <= 1'b0;
            green <= 1'b0;
            blue  <= 1'b0;
            x     <= '0;
            y     <= '0;
        end else if (rgb_en) begin
            {red, green, blue} <= rgb_nxt;
            x <= xc;
            y <= yc;
        end else begin
            {red, green, blue} <= 3'b000;
        end
    end

endmodule

// File: tb/tb_pixel_pattern_gen.sv
// Randomised and directed bench for pixel_pattern_gen against a
// coordinate-level reference model.
module tb_pixel_pattern_gen;

    localparam int H  = 640;
    localparam int V  = 480;
    localparam int BW = 80;

    logic       osc_clk = 1'b0;
    logic       reset = 1'b1;
    logic       h_sync_in = 1'b1;
    logic       v_sync_in = 1'b1;
    logic       rgb_en = 1'b0;
    logic       mode_next = 1'b0;
    logic       h_sync, v_sync, red, green, blue;
    logic [9:0] x;
    logic [8:0] y;
    logic [1:0] mode;

    int vectors = 0;
    int miscompares = 0;
    int red_cnt = 0;
    bit checking = 0;

    // reference model state
    int   m_col = 0, m_row = 0, m_mode = 0;
    bit   m_pend = 0, p_en = 0, p_vs = 1;
    logic [2:0] exp_rgb = 3'b000;
    int   exp_x = 0, exp_y = 0, exp_mode = 0;
    logic exp_hs = 1'b1, exp_vs = 1'b1;

    pixel_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .BAR_WIDTH(BW)) dut (
        .osc_clk  (osc_clk),
        .reset    (reset),
        .h_sync_in(h_sync_in),
        .v_sync_in(v_sync_in),
        .rgb_en   (rgb_en),
        .mode_next(mode_next),
        .h_sync   (h_sync),
        .v_sync   (v_sync),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .x        (x),
        .y        (y),
        .mode     (mode)
    );

    always #5 osc_clk = ~osc_clk;

    function automatic logic [2:0] colour(int md, int cx, int cy);
        int idx;
        logic [2:0] b;
        case (md)
            0: return 3'b100;
            1: begin
                idx = cx / BW;
                if (idx > 7) idx = 7;
                b = 3'(idx);
                return ~b;
            end
            2: return (cx % 16 == 0 || cy % 16 == 0 || cx == H - 1 || cy == V - 1)
                      ? 3'b111 : 3'b000;
            default: return (((cx / 32) % 2) != ((cy / 32) % 2)) ? 3'b111 : 3'b000;
        endcase
    endfunction

    always @(posedge osc_clk) begin
        bit fall, lend;
        if (reset) begin
            m_col = 0; m_row = 0; m_mode = 0; m_pend = 0;
            p_en = 0; p_vs = 1;
            exp_rgb = 3'b000; exp_x = 0; exp_y = 0;
            exp_hs = 1'b1; exp_vs = 1'b1; exp_mode = 0;
        end else begin
            exp_hs = h_sync_in;
            exp_vs = v_sync_in;
            if (rgb_en) begin
                exp_rgb = colour(m_mode, m_col, m_row);
                exp_x = m_col;
                exp_y = m_row;
            end else begin
                exp_rgb = 3'b000;
            end
            fall = p_vs && !v_sync_in;
            lend = p_en && !rgb_en;
            if (fall) begin
                if (m_pend || mode_next) m_mode = (m_mode + 1) % 4;
                m_pend = 0;
            end else if (mode_next) begin
                m_pend = 1;
            end
            m_col = rgb_en ? (m_col + 1) % H : 0;
            if (fall) m_row = 0;
            else if (lend && m_row < V - 1) m_row = m_row + 1;
            p_en = rgb_en;
            p_vs = v_sync_in;
            exp_mode = m_mode;
        end
    end

    always @(negedge osc_clk) begin
        if (red && !green && !blue) red_cnt++;
        if (checking) begin
            vectors++;
            if ({red, green, blue} !== exp_rgb) begin
                miscompares++;
                $display("FAIL rgb t=%0t got %b want %b", $time, {red, green, blue}, exp_rgb);
            end
            if (x !== 10'(exp_x) || y !== 9'(exp_y)) begin
                miscompares++;
                $display("FAIL xy t=%0t got %0d,%0d want %0d,%0d", $time, x, y, exp_x, exp_y);
            end
            if (h_sync !== exp_hs || v_sync !== exp_vs) begin
                miscompares++;
                $display("FAIL sync t=%0t got %b%b want %b%b", $time, h_sync, v_sync, exp_hs, exp_vs);
            end
            if (mode !== 2'(exp_mode)) begin
                miscompares++;
                $display("FAIL mode t=%0t got %0d want %0d", $time, mode, exp_mode);
            end
        end
    end

    task automatic chk(string name, int act, int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", name, act, req);
        end
    endtask

    task automatic step(logic e, logic v, logic m);
        rgb_en = e;
        h_sync_in = e;
        v_sync_in = v;
        mode_next = m;
        @(negedge osc_clk);
        mode_next = 1'b0;
    endtask

    task automatic line(int n, int mn_at);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'(i == mn_at));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic frame_edge(logic mn);
        step(1'b0, 1'b0, mn);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        bit en_r;
        chk("pin_bar_white", int'(colour(1, 0, 0)), 7);
        chk("pin_bar_6", int'(colour(1, 85, 0)), 6);
        chk("pin_bar_black", int'(colour(1, 639, 0)), 0);
        chk("pin_grid_edge", int'(colour(2, 639, 5)), 7);
        chk("pin_grid_off", int'(colour(2, 5, 5)), 0);
        chk("pin_check", int'(colour(3, 32, 0)), 7);
        chk("pin_check2", int'(colour(3, 32, 32)), 0);

        reset = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        checking = 1;
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("rst_mode", int'(mode), 0);
        chk("rst_x", int'(x), 0);
        chk("rst_rgb", int'({red, green, blue}), 0);
        chk("rst_sync", int'({h_sync, v_sync}), 3);
        reset = 1'b0;
        step(1'b0, 1'b1, 1'b0);

        frame_edge(1'b0);
        red_cnt = 0;
        line(640, -1);
        chk("red_line_cnt", red_cnt, 640);
        chk("red_line_lastx", int'(x), 639);

        line(100, 10);
        line(100, 50);
        line(100, 90);
        chk("pend_mode_hold", int'(mode), 0);
        step(1'b0, 1'b0, 1'b0);
        chk("advance_mode", int'(mode), 1);
        step(1'b0, 1'b1, 1'b0);
        line(640, -1);
        line(700, -1);
        frame_edge(1'b0);
        chk("no_second_adv", int'(mode), 1);

        step(1'b0, 1'b1, 1'b1);
        frame_edge(1'b0);
        chk("mode_grid", int'(mode), 2);
        repeat (3) line(640, -1);
        repeat (480) line(20, -1);
        chk("y_saturate", int'(y), 479);

        step(1'b0, 1'b1, 1'b1);
        frame_edge(1'b0);
        chk("mode_checker", int'(mode), 3);
        repeat (70) line(80, -1);
        frame_edge(1'b1);
        chk("wrap_on_edge", int'(mode), 0);
        frame_edge(1'b0);
        chk("pend_cleared", int'(mode), 0);

        en_r = 0;
        repeat (4000) begin
            if ($urandom_range(0, 59) == 0) en_r = ~en_r;
            step(en_r, 1'(($urandom_range(0, 299) != 0)),
                 1'(($urandom_range(0, 79) == 0)));
        end

        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4 && m_mode == 0; i++) begin
            step(1'b0, 1'b1, 1'b1);
            frame_edge(1'b0);
        end
        frame_edge(1'b0);
        repeat (200) line(4, -1);
        repeat (301) step(1'b1, 1'b1, 1'b0);
        chk("pre_rst_x", int'(x), 300);
        chk("pre_rst_y", int'(y), 200);
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        chk("mid_rst_x", int'(x), 0);
        chk("mid_rst_y", int'(y), 0);
        chk("mid_rst_rgb", int'({red, green, blue}), 0);
        chk("mid_rst_mode", int'(mode), 0);
        repeat (20) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("post_rst_x", int'(x), 0);
        chk("post_rst_y", int'(y), 0);
        chk("post_rst_mode", int'(mode), 0);
        line(50, -1);

        checking = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
